// File: rtl/ripple_add_sequencer.sv
// rtl/ripple_add_sequencer.sv - multi-cycle operand sequencer for a 3-bit ripple-carry adder slice
//
// Purpose: accepts WIDTH-bit operands on a valid/ready handshake and feeds them
// to an external combinational 3-bit adder one slice per cycle, LSB slice first.
// Each slice's COUT is registered as the next slice's carry-in. The returned SUM
// slices are assembled into a WIDTH-bit result, presented on a valid/ready output.
//
// Optional feature macro: RIPPLE_ADD_SEQ_SUB_EN
//   When defined, it adds the op_sub input. With op_sub=1 the block computes
//   op_a - op_b, and result_cout=1 means no borrow.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand handshake
//   op_a, op_b, op_cin       operands and initial carry
//   op_sub                   subtract select (only with RIPPLE_ADD_SEQ_SUB_EN)
//   add_a, add_b, add_cin    slice driven to the external adder
//   add_sum, add_cout        combinational return from the external adder
//   out_valid/out_ready      result handshake
//   result, result_cout      assembled sum and carry out of the top slice
module ripple_add_sequencer #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
`ifdef RIPPLE_ADD_SEQ_SUB_EN
  input  logic             op_sub,
`endif
  output logic [2:0]       add_a,
  output logic [2:0]       add_b,
  output logic             add_cin,
  input  logic [2:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_cout
);

  localparam int N  = WIDTH / 3;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic            carry_reg;
  logic [KW-1:0]   k;
  logic [IW-1:0]   base;
  logic            sub_sel;

`ifdef RIPPLE_ADD_SEQ_SUB_EN
  assign sub_sel = op_sub;
`else
  assign sub_sel = 1'b0;
`endif

  // Bit offset of the slice currently being presented to the adder.
  assign base = IW'(3 * k);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = 3'b000;
    add_b     = 3'b000;
    add_cin   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        add_a   = a_reg[base +: 3];
        add_b   = b_reg[base +: 3];
        add_cin = carry_reg;
        if (k == K_LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      carry_reg   <= 1'b0;
      k           <= '0;
      result      <= '0;
      result_cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg       <= op_a;
            // Subtraction is a + ~b + 1, so only B and the seed carry change.
            b_reg       <= sub_sel ? ~op_b : op_b;
            carry_reg   <= sub_sel ? 1'b1 : op_cin;
            k           <= '0;
            result      <= '0;
            result_cout <= 1'b0;
          end
        end
        RUN: begin
          result[base +: 3] <= add_sum;
          k                 <= k + 1'b1;
          // The top slice's carry is the final carry-out, not a ripple carry.
          if (k == K_LAST) result_cout <= add_cout;
          else             carry_reg   <= add_cout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ripple_add_sequencer.sv
// tb/tb_ripple_add_sequencer.sv - self-checking bench for ripple_add_sequencer
module tb_ripple_add_sequencer;

  localparam int W = 12;
  localparam int N = W / 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a, op_b;
  logic         op_cin;
  logic         op_sub;
  logic [2:0]   add_a, add_b;
  logic         add_cin;
  logic [2:0]   add_sum;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         result_cout;

  int errors = 0;
  int checks = 0;

  logic [W:0] sb[$];

  always #5 clk = ~clk;

  // Behavioural model of the external 3-bit adder slice.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {3'b000, add_cin};

  ripple_add_sequencer #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op_a(op_a),
    .op_b(op_b),
    .op_cin(op_cin),
`ifdef RIPPLE_ADD_SEQ_SUB_EN
    .op_sub(op_sub),
`endif
    .add_a(add_a),
    .add_b(add_b),
    .add_cin(add_cin),
    .add_sum(add_sum),
    .add_cout(add_cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .result_cout(result_cout)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] r;
    logic         c;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_result"}, 64'(result), 64'd0);
    check({tag, "_result_cout"}, 64'(result_cout), 64'd0);
    check({tag, "_add_bus"}, 64'({add_a, add_b, add_cin}), 64'd0);
  endtask

  // Issue one operation, track it to DONE, optionally hold backpressure, then retire it.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic [W-1:0] er, input logic ec,
                        input int hold, output logic [N-1:0] cins);
    int lat;
    logic busy_bad;
    logic stable_bad;
    logic [W:0] exp;
    logic [W-1:0] r0;
    logic c0;
    cins = '0;
    busy_bad = 1'b0;
    stable_bad = 1'b0;
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    op_cin = cin;
    op_sub = sub;
    sb.push_back({ec, er});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a = W'($urandom);
    op_b = W'($urandom);
    op_cin = 1'($urandom);
    op_sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (lat < N) cins[lat] = add_cin;
      if (in_ready) busy_bad = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    check("in_ready_busy", 64'(busy_bad), 64'd0);
    check("latency", 64'(lat), 64'(N));
    exp = sb.pop_front();
    if (!out_valid) return;
    r0 = result;
    c0 = result_cout;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      op_a = W'($urandom);
      op_b = W'($urandom);
      @(posedge clk);
      #1;
      if (!out_valid || in_ready || result !== r0 || result_cout !== c0) stable_bad = 1'b1;
    end
    in_valid = 1'b0;
    if (hold > 0) check("done_hold_stable", 64'(stable_bad), 64'd0);
    check("result", 64'(result), 64'(exp[W-1:0]));
    check("result_cout", 64'(result_cout), 64'(exp[W]));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("in_ready_after_done", 64'(in_ready), 64'd1);
    check("out_valid_after_done", 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [N-1:0] cins;
    logic [W:0]   m;
    vec_t         v;
    int           seen_valid;

    vecs.push_back('{a: 12'h123, b: 12'h456, cin: 1'b0, sub: 1'b0, r: 12'h579, c: 1'b0});
    vecs.push_back('{a: 12'hFFF, b: 12'h001, cin: 1'b0, sub: 1'b0, r: 12'h000, c: 1'b1});
    vecs.push_back('{a: 12'h000, b: 12'h000, cin: 1'b1, sub: 1'b0, r: 12'h001, c: 1'b0});
    vecs.push_back('{a: 12'h800, b: 12'h800, cin: 1'b0, sub: 1'b0, r: 12'h000, c: 1'b1});
    vecs.push_back('{a: 12'hABC, b: 12'h544, cin: 1'b1, sub: 1'b0, r: 12'h001, c: 1'b1});
    vecs.push_back('{a: 12'h7FF, b: 12'h000, cin: 1'b1, sub: 1'b0, r: 12'h800, c: 1'b0});
    vecs.push_back('{a: 12'hFFF, b: 12'hFFF, cin: 1'b1, sub: 1'b0, r: 12'hFFF, c: 1'b1});
`ifdef RIPPLE_ADD_SEQ_SUB_EN
    vecs.push_back('{a: 12'h010, b: 12'h011, cin: 1'b0, sub: 1'b1, r: 12'hFFF, c: 1'b0});
    vecs.push_back('{a: 12'h011, b: 12'h010, cin: 1'b0, sub: 1'b1, r: 12'h001, c: 1'b1});
    vecs.push_back('{a: 12'h005, b: 12'h005, cin: 1'b0, sub: 1'b1, r: 12'h000, c: 1'b1});
`endif
    for (int i = 0; i < 4; i++) begin
      v.a = W'($urandom);
      v.b = W'($urandom);
      v.cin = 1'($urandom);
      v.sub = 1'b0;
      m = {1'b0, v.a} + {1'b0, v.b} + {{W{1'b0}}, v.cin};
      v.r = m[W-1:0];
      v.c = m[W];
      vecs.push_back(v);
    end

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op_a = '0;
    op_b = '0;
    op_cin = 1'b0;
    op_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].r, vecs[i].c, 0, cins);
      if (i == 1) check("ripple_carry_slices", 64'(cins), 64'b1110);
    end

    // Backpressure for 10 cycles with in_valid asserted, then back-to-back ops.
    run_op(12'h321, 12'h111, 1'b0, 1'b0, 12'h432, 1'b0, 10, cins);
    run_op(12'h0F0, 12'h00F, 1'b1, 1'b0, 12'h100, 1'b0, 0, cins);

    // Reset while slice 2 is presented: operation is discarded.
    @(negedge clk);
    in_valid = 1'b1;
    op_a = 12'hFFF;
    op_b = 12'hFFF;
    op_cin = 1'b1;
    op_sub = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("slice2_add_a", 64'(add_a), 64'h7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_run_reset");
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid++;
    end
    check("no_valid_after_reset", 64'(seen_valid), 64'd0);
    run_op(12'h123, 12'h456, 1'b0, 1'b0, 12'h579, 1'b0, 0, cins);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
